// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port round-robin sequencer for a clockless single-port Ram
module ram_access_arbiter #(
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] ram_D,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);
    localparam int MAX_CYCLES = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] ACCESS_LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic            sel_q, we_q, last_grant, grant;

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not go last wins
                if (req0 && req1) grant = ~last_grant;
                else              grant = req1;
                if (req0 || req1) next_state = SETUP;
            end
            SETUP:   if (cnt == SETUP_LAST)  next_state = ACCESS;
            ACCESS:  if (cnt == ACCESS_LAST) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            last_grant <= 1'b1;
            ram_addr   <= '0;
            ram_D      <= '0;
            ram_en     <= 1'b0;
            ram_w      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state || state == IDLE) ? '0 : cnt + 1'b1;
            // Ram strobes are decoded from next_state so they are registered yet aligned with state
            ram_en <= (next_state == ACCESS);
            ram_w  <= (next_state == ACCESS) && we_q;
            ack0   <= (next_state == RELEASE) && !sel_q;
            ack1   <= (next_state == RELEASE) && sel_q;
            if (state == IDLE && next_state == SETUP) begin
                sel_q    <= grant;
                we_q     <= grant ? we1 : we0;
                ram_addr <= grant ? addr1 : addr0;
                ram_D    <= grant ? wdata1 : wdata0;
            end
            if (state == ACCESS && next_state == RELEASE && !we_q) begin
                if (sel_q) rdata1 <= ram_out;
                else       rdata0 <= ram_out;
            end
            if (state == RELEASE) last_grant <= sel_q;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;
    logic       clk, rst;
    logic       req0, we0, req1, we1, ack0, ack1, ram_w, ram_en, busy;
    logic [2:0] addr0, addr1, ram_addr;
    logic [7:0] wdata0, wdata1, rdata0, rdata1, ram_D, ram_out;

    logic       b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1, b_ram_w, b_ram_en, b_busy;
    logic [2:0] b_addr0, b_addr1, b_ram_addr;
    logic [7:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_ram_D, b_ram_out;

    logic [7:0] mem [8];
    int passed = 0, total = 0;

    ram_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_D(ram_D), .ram_w(ram_w), .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_out(ram_out), .busy(busy)
    );

    ram_access_arbiter #(.SETUP_CYCLES(2), .ACCESS_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
        .ram_D(b_ram_D), .ram_w(b_ram_w), .ram_addr(b_ram_addr), .ram_en(b_ram_en),
        .ram_out(b_ram_out), .busy(b_busy)
    );

    // Behavioural Ram: combinational read while enabled, write lands while en&w are high
    always @(posedge clk) if (ram_en && ram_w) mem[ram_addr] <= ram_D;
    assign ram_out = ram_en ? mem[ram_addr] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One transaction on dut; cycle 1 is the IDLE cycle in which the request is seen
    task automatic txn(input int p, input logic w, input logic [2:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] en_hist, output logic [7:0] w_hist,
                       output logic [7:0] r0, output logic [7:0] r1, output logic addr_ok);
        int cyc = 1;
        en_hist = '0; w_hist = '0; addr_ok = 1'b1;
        drive(p, 1'b1, w, a, d);
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc < 8) begin en_hist[cyc] = ram_en; w_hist[cyc] = ram_w; end
            if (ram_en && ram_addr !== a) addr_ok = 1'b0;
        end while (!(p == 1 ? ack1 : ack0) && cyc < 20);
        lat = cyc; r0 = rdata0; r1 = rdata1;
        drive(p, 1'b0, w, a, d);
        @(posedge clk); #1;
    endtask

    task automatic tie_round(output int first, output int second, output int c_first, output int c_second);
        int cyc = 1, n = 0;
        first = -1; second = -1; c_first = 0; c_second = 0;
        drive(0, 1'b1, 1'b1, 3'd2, 8'h22);
        drive(1, 1'b1, 1'b1, 3'd3, 8'h33);
        while (n < 2 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if ((p == 1) ? ack1 : ack0) begin
                    if (n == 0) begin first = p; c_first = cyc; end
                    else        begin second = p; c_second = cyc; end
                    n++;
                    drive(p, 1'b0, 1'b1, 3'd0, 8'h00);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        int         port;
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } vec_t;

    initial begin
        vec_t       vecs [11];
        int         lat, f, s, cf, cs, cyc, chg, rise, hi;
        logic [7:0] eh, wh, r0, r1;
        logic       aok, prev_en, noack;
        logic [2:0] prev_addr;
        logic       pend [2], pwe [2];
        logic [2:0] paddr [2];
        logic [7:0] pdata [2], model_mem [8], model_rd [2], rd_p, rd_q;
        int         age [2], expect_next;

        vecs[0]  = '{0, 1'b1, 3'd1, 8'h01, 8'h00, 8'h00};
        vecs[1]  = '{0, 1'b0, 3'd1, 8'h00, 8'h01, 8'h00};
        vecs[2]  = '{1, 1'b1, 3'd4, 8'h0B, 8'h01, 8'h00};
        vecs[3]  = '{0, 1'b1, 3'd1, 8'hA5, 8'h01, 8'h00};
        vecs[4]  = '{1, 1'b0, 3'd4, 8'h00, 8'h01, 8'h0B};
        vecs[5]  = '{0, 1'b0, 3'd1, 8'h00, 8'hA5, 8'h0B};
        vecs[6]  = '{1, 1'b1, 3'd7, 8'hFF, 8'hA5, 8'h0B};
        vecs[7]  = '{0, 1'b0, 3'd7, 8'h00, 8'hFF, 8'h0B};
        vecs[8]  = '{1, 1'b0, 3'd1, 8'h00, 8'hFF, 8'hA5};
        vecs[9]  = '{0, 1'b1, 3'd0, 8'h00, 8'hFF, 8'hA5};
        vecs[10] = '{0, 1'b0, 3'd0, 8'h00, 8'h00, 8'hA5};

        drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 3'd0; b_wdata0 = 8'h00;
        b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = 3'd0; b_wdata1 = 8'h00;
        b_ram_out = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ack0", ack0, 0);   check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);   check("rst_ram_en", ram_en, 0);
        check("rst_ram_w", ram_w, 0); check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_D", ram_D, 0); check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0); check("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, eh, wh, r0, r1, aok);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_en_seq", i), eh[4:2], 3'b010);
            check($sformatf("vec%0d_w_seq", i), wh[4:2], vecs[i].we ? 3'b010 : 3'b000);
            check($sformatf("vec%0d_addr_hold", i), aok, 1);
            check($sformatf("vec%0d_rdata0", i), r0, vecs[i].exp_r0);
            check($sformatf("vec%0d_rdata1", i), r1, vecs[i].exp_r1);
        end

        apply_reset();
        for (int r = 0; r < 2; r++) begin
            tie_round(f, s, cf, cs);
            check($sformatf("tie%0d_first", r), f, 0);
            check($sformatf("tie%0d_second", r), s, 1);
            check($sformatf("tie%0d_first_cyc", r), cf, 4);
            check($sformatf("tie%0d_second_cyc", r), cs, 8);
        end

        drive(0, 1'b1, 1'b1, 3'd6, 8'h66);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_pre_en", ram_en, 1);
        check("midrst_pre_w", ram_w, 1);
        rst = 1'b1;
        #1;
        check("midrst_en", ram_en, 0); check("midrst_w", ram_w, 0);
        check("midrst_busy", busy, 0); check("midrst_ack", ack0, 0);
        drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        noack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) noack = 1'b1;
        end
        check("midrst_no_ack", noack, 0);
        txn(0, 1'b0, 3'd1, 8'h00, lat, eh, wh, r0, r1, aok);
        check("post_rst_latency", lat, 4);
        check("post_rst_rdata0", r0, 8'hA5);

        // Setup/access ordering with the stretched timing instance
        cyc = 1; chg = 0; rise = 0; hi = 0; aok = 1'b1;
        prev_addr = b_ram_addr; prev_en = b_ram_en;
        b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 3'd5; b_wdata0 = 8'h55;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (b_ram_addr !== prev_addr && chg == 0) chg = cyc;
            if (b_ram_en && !prev_en) rise = cyc;
            if (b_ram_en) begin hi++; if (b_ram_addr !== 3'd5) aok = 1'b0; end
            prev_addr = b_ram_addr; prev_en = b_ram_en;
        end while (!b_ack0 && cyc < 20);
        b_req0 = 1'b0;
        check("b_en_after_addr", rise - chg, 2);
        check("b_en_high_cycles", hi, 3);
        check("b_addr_stable", aok, 1);
        check("b_ack_cycle", cyc, 7);
        @(posedge clk); #1;

        // Randomized traffic against a transaction-level model
        for (int a = 0; a < 8; a++) begin
            model_mem[a] = 8'($urandom);
            txn(0, 1'b1, 3'(a), model_mem[a], lat, eh, wh, r0, r1, aok);
        end
        model_rd[0] = 8'hA5; model_rd[1] = 8'h00;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; age[p] = 0; pwe[p] = 1'b0; paddr[p] = '0; pdata[p] = '0; end
        expect_next = -1;
        for (int t = 0; t < 440; t++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                rd_p = (p == 1) ? rdata1 : rdata0;
                rd_q = (p == 1) ? rdata0 : rdata1;
                if ((p == 1) ? ack1 : ack0) begin
                    check("rand_ack_pending", pend[p], 1);
                    if (expect_next >= 0) check("rand_rr_order", p, expect_next);
                    expect_next = pend[1-p] ? 1 - p : -1;
                    if (pend[p]) begin
                        if (pwe[p]) model_mem[paddr[p]] = pdata[p];
                        else        model_rd[p] = model_mem[paddr[p]];
                    end
                    check($sformatf("rand_rdata%0d", p), rd_p, model_rd[p]);
                    check($sformatf("rand_rdata%0d_iso", 1 - p), rd_q, model_rd[1-p]);
                    pend[p] = 1'b0;
                    drive(p, 1'b0, 1'b0, 3'd0, 8'h00);
                end else if (pend[p]) begin
                    age[p]++;
                    if (age[p] > 12) begin
                        check($sformatf("rand_timeout%0d", p), age[p], 12);
                        pend[p] = 1'b0;
                        drive(p, 1'b0, 1'b0, 3'd0, 8'h00);
                    end
                end else if (t < 400 && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1; age[p] = 0;
                    pwe[p] = 1'($urandom); paddr[p] = 3'($urandom); pdata[p] = 8'($urandom);
                    drive(p, 1'b1, pwe[p], paddr[p], pdata[p]);
                end
            end
        end
        check("rand_drain", {pend[0], pend[1]}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sequences and shares the 8x8 single-port Ram between two requesters (port 0, port 1).
- Ram has no clock; this block supplies a safe address→enable ordering:
  - address and data settle with en and w low;
  - then en (and w for writes) pulse;
  - then en and w drop before the address can change.
- Round-robin arbitration. Per-port request/acknowledge handshake. Registered read data per port.

Parameters:
- ADDR_W, 3, Ram address width (8 words)
- DATA_W, 8, Ram word width
- SETUP_CYCLES, 1, cycles ram_addr/ram_D are held with ram_en=0 before access (≥1)
- ACCESS_CYCLES, 1, cycles ram_en is held high (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  port 0 request; held high with fields stable until ack0
- we0  in  1  port 0: 1 = write, 0 = read
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 one-cycle completion pulse
- rdata0  out  DATA_W  port 0 read data, valid with ack0 on a read
- req1/we1/addr1/wdata1/ack1/rdata1: same as port 0, for port 1
- ram_D  out  DATA_W  to Ram D
- ram_w  out  1  to Ram w
- ram_addr  out  ADDR_W  to Ram addr
- ram_en  out  1  to Ram en
- ram_out  in  DATA_W  from Ram out
- busy  out  1  high whenever state ≠ IDLE

Behaviour:

Reset (async, immediate):
- state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie.

States:
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both request: grant the port ≠ last_grant.
  - On grant, latch sel, we, addr, wdata into internal registers → SETUP.
- SETUP:
  - ram_addr, ram_D = latched values; ram_en=0, ram_w=0.
  - Counts SETUP_CYCLES, then → ACCESS.
- ACCESS:
  - ram_en=1; ram_w=latched we.
  - ram_addr and ram_D unchanged.
  - Counts ACCESS_CYCLES, then → RELEASE.
  - For reads, ram_out is sampled on the final ACCESS edge into rdata[sel].
- RELEASE:
  - ram_en=0, ram_w=0; ram_addr and ram_D still held.
  - ack[sel]=1 for exactly this cycle; last_grant=sel.
  - → IDLE.

Timing and outputs:
- Latency, request seen in IDLE to ack: SETUP_CYCLES + ACCESS_CYCLES + 2 cycles (4 with defaults).
- All Ram-side outputs are registered (glitch-free).
- ram_addr and ram_D change only on the IDLE→SETUP transition. They hold the last value in IDLE.
- rdata0/rdata1 hold their value until the next read completion on the same port.
- A write never modifies rdata.

Handshake and ordering:
- Requester may drop or change req/fields on the edge ending the ack cycle.
- IDLE samples the new values the following cycle, so back-to-back transactions have 1 idle cycle between them.
- A request arriving while busy waits; there is no queueing beyond the req level.
- Requests are never lost: a waiting port is served next because of round-robin.
- A requester that deasserts req before ack is protocol violation. The transaction still completes and ack still pulses.
- Address wrap: none. The full ADDR_W range is valid.
- Reset asserted mid-transaction:
  - ram_en and ram_w drop asynchronously; state → IDLE; no ack.
  - The interrupted write may or may not have landed; the bench must not check that word.

Test Plan:
- Write then read, port 0: req0, we0=1, addr0=1, wdata0=0x01 → ram_addr=1 with ram_en=0 for 1 cycle, then ram_en=ram_w=1 for 1 cycle, then ack0 at cycle 4. Then a read of addr 1 → ack0 with rdata0=0x01 and ram_w=0 throughout.
- Two addresses: write 0x0B to addr 4 via port 1, write 0xA5 to addr 1 via port 0 → reading addr 4 returns 0x0B and addr 1 returns 0xA5. Neither write overwrites the other.
- Simultaneous requests from reset: req0 and req1 both high → port 0 served first, then port 1 with no idle gap beyond the 1 IDLE cycle. Repeat the tie → ordering alternates.
- Setup/en ordering check, SETUP_CYCLES=2 and ACCESS_CYCLES=3:
  - ram_en rises exactly 2 cycles after ram_addr changes and stays high 3 cycles;
  - ram_addr is never different while ram_en=1;
  - ack arrives 7 cycles after the request.
- Reset mid-ACCESS of a write to addr 6 → ram_en and ram_w go 0 immediately; busy=0; no ack; the next request is served normally from IDLE.
- Reads and rdata isolation:
  - port 1 read → rdata0 unchanged;
  - port 0 write → rdata0 retains the previous read value;
  - read of an address written with 0xFF → returns 0xFF.
